// File: rtl/mips150_store_unit_if.sv
// Store request channel from the MEM stage plus the write channel toward dmem/MMIO.
// The slave modport is the store unit's view, and the master modport is the surrounding datapath's view.
interface mips150_store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mips150_store_unit.sv
// SB/SH/SW to word-aligned byte-enabled writes, queued DEPTH deep toward dmem; 1 cycle min latency.
// Stalls st_ready only when the queue is full and the head is not leaving; misaligned stores are dropped.
module mips150_store_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  mips150_store_unit_if.slave   bus,
  output logic                  misalign,
  output logic [CNT_W-1:0]      misalign_cnt,
  output logic                  empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [29:0] addr_mem_q [DEPTH];
  logic [3:0]  we_mem_q   [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  logic        bad;
  logic [3:0]  enc_we;
  logic [31:0] enc_wdata;
  logic        deq, accept, enq;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    bad       = 1'b0;
    enc_we    = 4'b0000;
    enc_wdata = bus.st_data;
    case (bus.st_size)
      2'b00: begin
        enc_we    = 4'b1000 >> bus.st_addr[1:0];
        enc_wdata = {4{bus.st_data[7:0]}};
      end
      2'b01: begin
        bad       = bus.st_addr[0];
        enc_we    = bus.st_addr[1] ? 4'b0011 : 4'b1100;
        enc_wdata = {2{bus.st_data[15:0]}};
      end
      2'b10: begin
        bad    = (bus.st_addr[1:0] != 2'b00);
        enc_we = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    deq          = (count_q != '0) && bus.mem_ready;
    bus.st_ready = (count_q < DEPTH_C) || deq;
    accept       = bus.st_valid && bus.st_ready;
    enq          = accept && !bad && !flush;
    misalign_d   = accept && bad && !flush;
    cnt_d        = (misalign_d && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    wr_ptr_d     = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Entry storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= bus.st_addr[31:2];
      we_mem_q[wr_ptr_q]   <= enc_we;
      data_mem_q[wr_ptr_q] <= enc_wdata;
    end
  end

  always_comb begin
    bus.mem_valid = (count_q != '0);
    bus.mem_addr  = bus.mem_valid ? {addr_mem_q[rd_ptr_q], 2'b00} : 32'h0;
    bus.mem_we    = bus.mem_valid ? we_mem_q[rd_ptr_q] : 4'b0000;
    bus.mem_wdata = bus.mem_valid ? data_mem_q[rd_ptr_q] : 32'h0;
    empty         = (count_q == '0);
    misalign      = misalign_q;
    misalign_cnt  = cnt_q;
  end
endmodule
